// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller: register
// address width, multiply/divide FSM encoding and pipeline control words.
package hazard_control_unit_pkg;

    localparam int REG_ADDRESS_LENGTH = 5;
    localparam int DEFAULT_MUL_LAT    = 4;
    localparam int DEFAULT_DIV_LAT    = 32;
    localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

    typedef logic [REG_ADDRESS_LENGTH-1:0] reg_addr_t;

    typedef enum logic {
        HCU_IDLE    = 1'b0,
        HCU_MD_BUSY = 1'b1
    } hcu_state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN      = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam pipe_ctrl_t CTRL_STALL    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam pipe_ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};

    // $0 is hard-wired to zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(input reg_addr_t ex_rt, input reg_addr_t id_rs,
                                          input reg_addr_t id_rt, input logic id_uses_rt);
        return (ex_rt != '0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle of the hazard controller: ID/EX decode inputs in,
// pipeline-register enables, flushes and status out.
interface hazard_control_unit_if;
    import hazard_control_unit_pkg::*;

    reg_addr_t   ID_Rs;
    reg_addr_t   ID_Rt;
    logic        ID_UsesRt;
    logic        ID_UsesHiLo;
    logic        ID_IsMD;
    reg_addr_t   EX_Rt;
    logic        EX_MemRead;
    logic        EX_MDStart;
    logic        EX_MDIsDiv;
    logic        EX_BranchTaken;
    logic        PC_Write;
    logic        IFID_Write;
    logic        IFID_Flush;
    logic        IDEX_Flush;
    logic        MD_Busy;
    logic [15:0] Stall_Count;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_UsesHiLo, ID_IsMD,
        output EX_Rt, EX_MemRead, EX_MDStart, EX_MDIsDiv, EX_BranchTaken,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Busy, Stall_Count
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_UsesHiLo, ID_IsMD,
        input  EX_Rt, EX_MemRead, EX_MDStart, EX_MDIsDiv, EX_BranchTaken,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Busy, Stall_Count
    );

endinterface

// File: rtl/md_busy_counter.sv
// Tracks the multi-cycle multiply/divide unit: IDLE/MD_BUSY FSM plus a
// down-counter that releases the unit LAT cycles after issue in EX.
module md_busy_counter
    import hazard_control_unit_pkg::*;
#(
    parameter int MUL_LAT = DEFAULT_MUL_LAT,
    parameter int DIV_LAT = DEFAULT_DIV_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam int CNT_W = $clog2(DIV_LAT);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hcu_state_t       state, state_next;
    logic [CNT_W-1:0] md_cnt, md_cnt_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HCU_IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // NOTE: defaults at the top of the block keep every path assigned, so no
    // latch is inferred for the next-state signals.
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        unique case (state)
            HCU_IDLE: begin
                if (md_start) begin
                    state_next  = HCU_MD_BUSY;
                    md_cnt_next = md_is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            HCU_MD_BUSY: begin
                // A new issue while busy is stalled upstream, so md_start is ignored here.
                if (md_cnt == CNT_ONE) begin
                    state_next  = HCU_IDLE;
                    md_cnt_next = '0;
                end else begin
                    md_cnt_next = md_cnt - CNT_ONE;
                end
            end
            default: begin
                state_next  = HCU_IDLE;
                md_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        md_busy = (state == HCU_MD_BUSY);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller beside ID/EX: load-use and multiply/divide hazards,
// taken-branch redirects, and a saturating stall-cycle counter.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MUL_LAT = DEFAULT_MUL_LAT,
    parameter int DIV_LAT = DEFAULT_DIV_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_control_unit_if.slave hcu
);

    logic        md_busy;
    logic        load_haz;
    logic        md_haz;
    logic        stall;
    pipe_ctrl_t  ctrl;
    logic [15:0] stall_count;

    md_busy_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .md_start  (hcu.EX_MDStart),
        .md_is_div (hcu.EX_MDIsDiv),
        .md_busy   (md_busy)
    );

    always_comb begin
        load_haz = hcu.EX_MemRead &&
                   load_use_hit(hcu.EX_Rt, hcu.ID_Rs, hcu.ID_Rt, hcu.ID_UsesRt);
        md_haz   = (md_busy || hcu.EX_MDStart) && (hcu.ID_UsesHiLo || hcu.ID_IsMD);
        stall    = rst_n && !hcu.EX_BranchTaken && (load_haz || md_haz);

        // Reset forces free-running control; a redirect outranks any hazard
        // because the instruction in ID is on the wrong path.
        if (!rst_n) begin
            ctrl = CTRL_RUN;
        end else if (hcu.EX_BranchTaken) begin
            ctrl = CTRL_REDIRECT;
        end else if (load_haz || md_haz) begin
            ctrl = CTRL_STALL;
        end else begin
            ctrl = CTRL_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != STALL_COUNT_MAX)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    assign hcu.PC_Write    = ctrl.pc_write;
    assign hcu.IFID_Write  = ctrl.ifid_write;
    assign hcu.IFID_Flush  = ctrl.ifid_flush;
    assign hcu.IDEX_Flush  = ctrl.idex_flush;
    assign hcu.MD_Busy     = md_busy;
    assign hcu.Stall_Count = stall_count;

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage MIPS core: the stall/flush side of the operand-bypass logic. It detects the hazards the forwarding unit cannot cover and drives the pipeline-register enables and flushes:
- load-use dependencies;
- HI/LO reads and new multiply/divide issues while the multi-cycle multiply/divide unit is busy;
- taken-branch redirects resolved in EX.

It sits beside the ID/EX pipeline register and also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `MUL_LAT`, default 4: multiply latency in cycles, counted from issue in EX. Must be ≥ 2.
- `DIV_LAT`, default 32: divide latency in cycles. Must be ≥ 2.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `ID_Rs`, `ID_Rt` input `REG_ADDRESS_LENGTH`: source registers of the instruction in ID.
- `ID_UsesRt` input 1: the instruction in ID actually reads Rt.
- `ID_UsesHiLo` input 1: the instruction in ID is mfhi/mflo.
- `ID_IsMD` input 1: the instruction in ID is mult/multu/div/divu.
- `EX_Rt` input `REG_ADDRESS_LENGTH`: load destination of the instruction in EX.
- `EX_MemRead` input 1: the instruction in EX is a load.
- `EX_MDStart` input 1: a multiply/divide is issuing from EX this cycle.
- `EX_MDIsDiv` input 1: qualifies `EX_MDStart`. 1 = divide, 0 = multiply.
- `EX_BranchTaken` input 1: the branch/jump in EX resolved taken.
- `PC_Write` output 1: PC enable.
- `IFID_Write` output 1: IF/ID register enable.
- `IFID_Flush` output 1: zero IF/ID.
- `IDEX_Flush` output 1: insert a bubble into ID/EX.
- `MD_Busy` output 1: the multiply/divide unit is busy.
- `Stall_Count` output 16: number of stalled cycles since reset.

## Operation
- FSM states: `IDLE` and `MD_BUSY`, plus a down-counter `md_cnt` of width clog2(`DIV_LAT`).
- `IDLE` → `MD_BUSY` on `EX_MDStart`. `md_cnt` loads `DIV_LAT`-1 if `EX_MDIsDiv`, else `MUL_LAT`-1.
- In `MD_BUSY`:
  - if `md_cnt`==1, go to `IDLE` and set `md_cnt`=0;
  - otherwise decrement `md_cnt`;
  - `EX_MDStart` is ignored (it cannot legally occur, because issue is stalled).
- `MD_Busy` = (state == `MD_BUSY`).
- `load_haz` = `EX_MemRead` && `EX_Rt` != 0 && (`EX_Rt`==`ID_Rs` || (`ID_UsesRt` && `EX_Rt`==`ID_Rt`)).
- `md_haz` = (`MD_Busy` || `EX_MDStart`) && (`ID_UsesHiLo` || `ID_IsMD`).
- Priority 1, `EX_BranchTaken`:
  - `IFID_Flush`=1, `IDEX_Flush`=1, `PC_Write`=1, `IFID_Write`=1.
  - Hazards are ignored because the ID instruction is wrong-path.
  - The FSM still advances; an older in-flight multiply/divide is not cancelled.
- Priority 2, `load_haz` || `md_haz`: `PC_Write`=0, `IFID_Write`=0, `IDEX_Flush`=1, `IFID_Flush`=0.
- Otherwise: `PC_Write`=1, `IFID_Write`=1, both flushes 0.
- `Stall_Count` increments on every edge where the priority-2 stall is active. It saturates at 16'hFFFF.
- Register $0 never causes a load-use stall.

## Timing
- Stall/flush outputs are combinational from the inputs and state, valid in the same cycle; zero latency.
- A load-use hazard produces exactly one bubble. The next cycle the load has moved to MEM (`EX_MemRead`=0 in EX) and forwarding covers it.
- A multiply/divide issued in cycle T:
  - `MD_Busy` is high in T+1 … T+LAT-1;
  - `md_haz` stalls dependent ID instructions in T … T+LAT-1;
  - HI/LO are readable in ID at T+LAT.
- Reset (`rst_n` low, asynchronous, including mid-`MD_BUSY`):
  - state=`IDLE`, `md_cnt`=0, `Stall_Count`=0, `MD_Busy`=0;
  - `PC_Write`=1, `IFID_Write`=1, `IFID_Flush`=0, `IDEX_Flush`=0, forced regardless of inputs.
- Operation resumes on the first rising edge after `rst_n` rises.

## Structure
- Shared `defines.v` holds `REG_ADDRESS_LENGTH` (existing), FSM state encodings (`HCU_IDLE`, `HCU_MD_BUSY`), and default latencies.
- One sub-module, `md_busy_counter`, covers the FSM, `md_cnt` and `MD_Busy`, taking `EX_MDStart`/`EX_MDIsDiv`.
- Hazard decode, priority muxing and `Stall_Count` live in the top level.

## Test plan
- **Load-use:** `EX_MemRead`=1, `EX_Rt`=5, `ID_Rs`=5 → one cycle of `PC_Write`=0, `IFID_Write`=0, `IDEX_Flush`=1. `Stall_Count` 0→1. Repeat with `EX_Rt`=0 → no stall.
- **Rt gating:** `EX_Rt`=7=`ID_Rt` with `ID_UsesRt`=0 → no stall; with `ID_UsesRt`=1 → stall.
- **Multiply then mfhi:** `EX_MDStart`=1, `EX_MDIsDiv`=0 at T, `ID_UsesHiLo`=1 held → stall in T…T+3, `MD_Busy` high T+1…T+3, released at T+4, `Stall_Count`=4.
- **Divide:** `EX_MDIsDiv`=1 → `MD_Busy` for 31 cycles. An `EX_BranchTaken` pulse mid-busy → both flushes high that cycle, no stall, `MD_Busy` unaffected.
- **Reset mid-divide:** assert `rst_n`=0 at busy cycle 10 → `MD_Busy`=0, `Stall_Count`=0 immediately (asynchronous); after release, `ID_IsMD`=1 → no stall.
- **Saturation:** hold a stall for 65 540 cycles → `Stall_Count` stops at 16'hFFFF.
